// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants, slot record and helpers for the pipeline hazard controller
package hazard_pkg;
  localparam logic [1:0] TUSE_D = 2'd0, TUSE_E = 2'd1, TUSE_M = 2'd2, TUSE_NONE = 2'd3;
  localparam logic [1:0] TNEW_0 = 2'd0, TNEW_ALU = 2'd1, TNEW_LOAD = 2'd2;
  localparam logic [1:0] FWD_RF = 2'd0, FWD_E = 2'd1, FWD_M = 2'd2, FWD_W = 2'd2;
  // the E-stage mux numbers its sources from M, so M is select 1 there
  localparam logic [1:0] FWD_E_M = 2'd1;
  localparam logic [1:0] MD_NONE = 2'd0, MD_MULT = 2'd1, MD_DIV = 2'd2;
  typedef struct packed {
    logic [4:0] a3;
    logic we;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [1:0] md;
  } slot_t;
  function automatic logic hit(slot_t s, logic [4:0] r);
    return s.we && s.a3 != 5'd0 && s.a3 == r;
  endfunction
  function automatic slot_t age(slot_t s);
    slot_t o;
    o = s;
    o.tnew = s.tnew == TNEW_0 ? TNEW_0 : s.tnew - 2'd1;
    return o;
  endfunction
endpackage

// File: rtl/md_busy_ctr.sv
// md_busy_ctr: mult/div busy countdown, loaded as the start instruction leaves E
module md_busy_ctr import hazard_pkg::*; #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic [1:0] e_md_start,
  output logic md_busy
);
  localparam int W = $clog2((MULT_CYC > DIV_CYC ? MULT_CYC : DIV_CYC) + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (reset || flush) cnt <= '0;
    else if (e_md_start == MD_MULT) cnt <= W'(MULT_CYC);
    else if (e_md_start == MD_DIV) cnt <= W'(DIV_CYC);
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign md_busy = cnt != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/forward control for the 5-stage pipeline; HAZARD_PERF_EN adds a stall-cycle counter
module hazard_ctrl import hazard_pkg::*; #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_a3,
  input  logic d_we,
  input  logic [1:0] d_tnew,
  input  logic d_md_use,
  input  logic [1:0] d_md_start,
  output logic stall,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic fwd_m_rt,
  output logic md_busy,
  output logic [31:0] stall_cnt
);
  slot_t e, m;
  logic [4:0] w_a3;
  logic w_we;
  logic rs_haz, rt_haz, md_haz;
  md_busy_ctr #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) u_md (
    .clk(clk), .reset(reset), .flush(flush), .e_md_start(e.md), .md_busy(md_busy)
  );
  assign rs_haz = d_tuse_rs != TUSE_NONE &&
                  ((hit(e, d_rs) && d_tuse_rs < e.tnew) || (hit(m, d_rs) && d_tuse_rs < m.tnew));
  assign rt_haz = d_tuse_rt != TUSE_NONE &&
                  ((hit(e, d_rt) && d_tuse_rt < e.tnew) || (hit(m, d_rt) && d_tuse_rt < m.tnew));
  assign md_haz = d_md_use && (md_busy || e.md != MD_NONE);
  assign stall = rs_haz || rt_haz || md_haz;
  assign fwd_d_rs = hit(e, d_rs) && e.tnew == TNEW_0 ? FWD_E :
                    hit(m, d_rs) && m.tnew == TNEW_0 ? FWD_M : FWD_RF;
  assign fwd_d_rt = hit(e, d_rt) && e.tnew == TNEW_0 ? FWD_E :
                    hit(m, d_rt) && m.tnew == TNEW_0 ? FWD_M : FWD_RF;
  assign fwd_e_rs = hit(m, e.rs) && m.tnew == TNEW_0 ? FWD_E_M :
                    w_we && w_a3 != 5'd0 && w_a3 == e.rs ? FWD_W : FWD_RF;
  assign fwd_e_rt = hit(m, e.rt) && m.tnew == TNEW_0 ? FWD_E_M :
                    w_we && w_a3 != 5'd0 && w_a3 == e.rt ? FWD_W : FWD_RF;
  assign fwd_m_rt = w_we && w_a3 != 5'd0 && w_a3 == m.rt;
  // W only feeds forwarding, so it keeps just the destination
  always_ff @(posedge clk)
    if (reset) begin
      e <= '0;
      m <= '0;
      w_a3 <= '0;
      w_we <= 1'b0;
    end else begin
      w_a3 <= m.a3;
      w_we <= m.we;
      m <= flush ? '0 : age(e);
      e <= flush || stall ? '0 : slot_t'{a3: d_a3, we: d_we, tnew: d_tnew, rs: d_rs, rt: d_rt, md: d_md_start};
    end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk)
    if (reset) stall_cnt <= '0;
    else if (stall) stall_cnt <= stall_cnt + 32'd1;
`else
  assign stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a stage-list reference model
module tb_hazard_ctrl;
  localparam int MULT_CYC = 5, DIV_CYC = 10;
  logic clk = 1'b0;
  logic reset, flush, d_we, d_md_use, stall, fwd_m_rt, md_busy;
  logic [4:0] d_rs, d_rt, d_a3;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_start, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  logic [31:0] stall_cnt;
  always #5 clk = ~clk;
  hazard_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .flush(flush), .d_rs(d_rs), .d_rt(d_rt),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_a3(d_a3), .d_we(d_we), .d_tnew(d_tnew),
    .d_md_use(d_md_use), .d_md_start(d_md_start), .stall(stall), .fwd_d_rs(fwd_d_rs),
    .fwd_d_rt(fwd_d_rt), .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );
  typedef struct { int a3; int we; int tnew; int rs; int rt; int md; } ent_t;
  ent_t zero = '{default: 0};
  ent_t pipe[3];
  int cyc = 0, md_free_at = 0, checks = 0, errors = 0;
  int unsigned perf = 0;
  logic obs_stall;
  function automatic int writes(int k, int r);
    return pipe[k].we != 0 && pipe[k].a3 != 0 && pipe[k].a3 == r;
  endfunction
  function automatic int hz(int r, int tuse);
    if (tuse == 3 || r == 0) return 0;
    for (int k = 0; k < 2; k++) if (writes(k, r) != 0 && tuse < pipe[k].tnew) return 1;
    return 0;
  endfunction
  // select = distance from the consumer to the nearest stage holding a ready value
  function automatic int src(int r, int first);
    for (int k = first; k <= first + 1; k++)
      if (writes(k, r) != 0 && (k == 2 || pipe[k].tnew == 0)) return k - first + 1;
    return 0;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int rs, input int rt, input int tur, input int tut, input int a3,
                      input int we, input int tn, input int mu, input int ms, input int fl, input int rst);
    int es;
    @(negedge clk);
    d_rs = 5'(rs); d_rt = 5'(rt); d_tuse_rs = 2'(tur); d_tuse_rt = 2'(tut); d_a3 = 5'(a3);
    d_we = 1'(we); d_tnew = 2'(tn); d_md_use = 1'(mu); d_md_start = 2'(ms);
    flush = 1'(fl); reset = 1'(rst);
    #1;
    es = (hz(rs, tur) != 0 || hz(rt, tut) != 0 || (mu != 0 && (cyc < md_free_at || pipe[0].md != 0))) ? 1 : 0;
    check("stall", 32'(stall), 32'(es));
    check("fwd_d_rs", 32'(fwd_d_rs), 32'(src(rs, 0)));
    check("fwd_d_rt", 32'(fwd_d_rt), 32'(src(rt, 0)));
    check("fwd_e_rs", 32'(fwd_e_rs), 32'(src(pipe[0].rs, 1)));
    check("fwd_e_rt", 32'(fwd_e_rt), 32'(src(pipe[0].rt, 1)));
    check("fwd_m_rt", 32'(fwd_m_rt), 32'(writes(2, pipe[1].rt)));
    check("md_busy", 32'(md_busy), 32'(cyc < md_free_at));
`ifdef HAZARD_PERF_EN
    check("stall_cnt", stall_cnt, perf);
`else
    check("stall_cnt", stall_cnt, 32'd0);
`endif
    obs_stall = stall;
    @(posedge clk);
    if (rst != 0) begin
      foreach (pipe[k]) pipe[k] = zero;
      md_free_at = 0;
      perf = 0;
    end else begin
      if (es != 0) perf++;
      if (fl != 0) begin
        pipe[2] = pipe[1]; pipe[1] = zero; pipe[0] = zero; md_free_at = 0;
      end else begin
        if (pipe[0].md == 1) md_free_at = cyc + 1 + MULT_CYC;
        else if (pipe[0].md == 2) md_free_at = cyc + 1 + DIV_CYC;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (pipe[1].tnew > 0) pipe[1].tnew--;
        pipe[0] = es != 0 ? zero : '{a3: a3, we: we, tnew: tn, rs: rs, rt: rt, md: ms};
      end
    end
    cyc++;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    d_rs = 0; d_rt = 0; d_tuse_rs = 3; d_tuse_rt = 3; d_a3 = 0; d_we = 0; d_tnew = 0;
    d_md_use = 0; d_md_start = 0; flush = 0; reset = 1;
    repeat (2) @(posedge clk);
    foreach (pipe[k]) pipe[k] = zero;
    step(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    // load-use: lw $8 then add using $8 in E
    step(0, 0, 3, 3, 8, 1, 2, 0, 0, 0, 0);
    step(8, 0, 1, 3, 9, 1, 1, 0, 0, 0, 0);
    check("t1_stall", 32'(obs_stall), 32'd1);
    step(8, 0, 1, 3, 9, 1, 1, 0, 0, 0, 0);
    step(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    // ALU result feeding a branch
    step(0, 0, 3, 3, 3, 1, 1, 0, 0, 0, 0);
    step(3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    check("t2_stall", 32'(obs_stall), 32'd1);
    step(3, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    check("t2_fwd", 32'(fwd_d_rs), 32'd2);
    // writer of $0 never stalls or forwards
    step(0, 0, 3, 3, 0, 1, 2, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("t3_stall", 32'(obs_stall), 32'd0);
    // div then mflo waits DIV_CYC+1 cycles
    step(1, 2, 0, 0, 0, 0, 0, 1, 2, 0, 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 3, 3, 4, 1, 1, 1, 0, 0, 0);
      if (!obs_stall) break;
      n++;
    end
    check("t4_md_stalls", n, DIV_CYC + 1);
    // flush while a load stalls D
    step(0, 0, 3, 3, 5, 1, 2, 0, 1, 0, 0);
    step(5, 0, 0, 3, 0, 0, 0, 0, 0, 1, 0);
    step(5, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0);
    check("t5_stall", 32'(obs_stall), 32'd0);
    check("t5_busy", 32'(md_busy), 32'd0);
    // stall cycles then reset clears the counter
    step(0, 0, 3, 3, 6, 1, 2, 0, 0, 0, 0);
    step(6, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    step(6, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    step(6, 0, 0, 3, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0);
    check("t6_cnt_reset", stall_cnt, 32'd0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 2),
           $urandom_range(0, 3) == 0 ? 1 : 0,
           $urandom_range(0, 9) == 0 ? $urandom_range(1, 2) : 0,
           $urandom_range(0, 19) == 0 ? 1 : 0, $urandom_range(0, 199) == 0 ? 1 : 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
